// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared constants, regime clamps and stage1 payload for the posit encoder
// POSIT_RNE_EN adds guard/sticky to the payload for round-to-nearest-even.
package posit_pkg;

  function automatic int log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int N_DEF  = 8;
  localparam int ES_DEF = 3;
  localparam int RS_DEF = log2(N_DEF);

  localparam int K_MAX = N_DEF - 2;
  localparam int K_MIN = -(N_DEF - 1);

  typedef struct packed {
    logic              sign;
    logic              sat;
    logic [N_DEF-2:0]  mag;
`ifdef POSIT_RNE_EN
    logic              guard;
    logic              sticky;
`endif
  } s1_payload_t;

endpackage

// File: rtl/posit_construction_if.sv
// rtl/posit_construction_if.sv - field input and posit output handshake bundle
// Master drives fields and out_ready; slave (the encoder) drives in_ready and the result.
interface posit_construction_if #(
  parameter int N  = 8,
  parameter int ES = 3,
  parameter int RS = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 Sign;
  logic signed [RS:0]   RegimeValue;
  logic [ES-1:0]        Exponent;
  logic [N-ES+2:0]      Mantissa;
  logic                 out_valid;
  logic                 out_ready;
  logic [N-1:0]         Result;

  modport master (
    output in_valid, Sign, RegimeValue, Exponent, Mantissa, out_ready,
    input  in_ready, out_valid, Result
  );

  modport slave (
    input  in_valid, Sign, RegimeValue, Exponent, Mantissa, out_ready,
    output in_ready, out_valid, Result
  );
endinterface

// File: rtl/posit_regime_encoder.sv
// rtl/posit_regime_encoder.sv - left-aligned regime run for regime value k, plus run length
module posit_regime_encoder #(
  parameter int N  = 8,
  parameter int RS = 3
) (
  input  logic signed [RS:0] k,
  output logic [N:0]         pattern,
  output logic [RS:0]        len
);
  logic [RS:0] mag_k;

  always_comb begin
    mag_k   = '0;
    pattern = '0;
    len     = '0;
    if (k[RS]) begin
      // -k zeros then a terminating one; unsigned view keeps k = -2^RS representable
      mag_k   = (~$unsigned(k)) + 1'b1;
      len     = mag_k + (RS+1)'(1);
      pattern = {1'b1, {N{1'b0}}} >> mag_k;
    end else begin
      mag_k   = $unsigned(k);
      len     = mag_k + (RS+1)'(2);
      pattern = ~({(N+1){1'b1}} >> (mag_k + 1'b1));
    end
  end
endmodule

// File: rtl/posit_construction.sv
// rtl/posit_construction.sv - two-stage elastic posit encoder (regime pack, then round/sign)
// POSIT_RNE_EN selects round-to-nearest-even; otherwise the magnitude is truncated.
module posit_construction
  import posit_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int ES = ES_DEF,
  parameter int RS = RS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  posit_construction_if.slave bus
);
  localparam int W = 2*N + ES;
  localparam logic signed [RS:0] K_HI = (RS+1)'(K_MAX);
  localparam logic signed [RS:0] K_LO = (RS+1)'(K_MIN);

  logic [N:0]    reg_pat;
  logic [RS:0]   reg_len;
  logic [W-1:0]  ext;
  logic          sat_hi, sat_lo;
  s1_payload_t   s1_d, s1_q;
  logic          s1_valid, s2_valid, s2_advance;
  logic          round_up;
  logic [N-1:0]  sum;
  logic [N-2:0]  mag_r;
  logic [N-1:0]  result_d, result_q;
  logic          unused_bits;

  posit_regime_encoder #(.N(N), .RS(RS)) u_regime (
    .k       (bus.RegimeValue),
    .pattern (reg_pat),
    .len     (reg_len)
  );

  always_comb begin
    ext = {reg_pat, {(W-N-1){1'b0}}}
        | ({bus.Exponent, bus.Mantissa[N-ES+1:0], {(W-N-2){1'b0}}} >> reg_len);
    sat_hi = (bus.RegimeValue >= K_HI);
    sat_lo = (bus.RegimeValue <= K_LO);
    s1_d      = '0;
    s1_d.sign = bus.Sign;
    s1_d.sat  = sat_hi | sat_lo;
    if (sat_hi)      s1_d.mag = '1;
    else if (sat_lo) s1_d.mag = {{(N-2){1'b0}}, 1'b1};
    else             s1_d.mag = ext[W-1 -: N-1];
`ifdef POSIT_RNE_EN
    s1_d.guard  = ext[W-N];
    s1_d.sticky = |ext[W-N-1:0];
`endif
  end

`ifdef POSIT_RNE_EN
  assign round_up    = s1_q.guard & (s1_q.sticky | s1_q.mag[0]);
  assign unused_bits = bus.Mantissa[N-ES+2];
`else
  assign round_up    = 1'b0;
  assign unused_bits = ^{bus.Mantissa[N-ES+2], ext[W-N:0]};
`endif

  always_comb begin
    sum = {1'b0, s1_q.mag} + {{(N-1){1'b0}}, round_up};
    if (s1_q.sat)     mag_r = s1_q.mag;
    else if (sum[N-1]) mag_r = '1;
    else              mag_r = sum[N-2:0];
    // zero and NaR are unreachable: the smallest magnitude is minpos
    if (mag_r == '0)  mag_r = {{(N-2){1'b0}}, 1'b1};
    result_d = s1_q.sign ? (~{1'b0, mag_r} + 1'b1) : {1'b0, mag_r};
  end

  assign s2_advance    = !s2_valid || bus.out_ready;
  assign bus.in_ready  = !s1_valid || s2_advance;
  assign bus.out_valid = s2_valid;
  assign bus.Result    = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s2_valid <= 1'b0;
      result_q <= '0;
    end else begin
      if (bus.in_ready) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) s1_q <= s1_d;
      end
      if (s2_advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) result_q <= result_d;
      end
    end
  end
endmodule

// File: tb/tb_posit_construction.sv
// tb/tb_posit_construction.sv - directed-vector bench for the posit encoder (N=8, ES=3)
module tb_posit_construction;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  posit_construction_if #(.N(8), .ES(3), .RS(3)) bus ();
  posit_construction dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

`ifdef POSIT_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  typedef struct {
    string             tag;
    logic              s;
    logic signed [3:0] k;
    logic [2:0]        e;
    logic [7:0]        m;
    logic [7:0]        x;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(string tag, logic s, int k, logic [2:0] e,
                              logic [7:0] m, logic [7:0] x);
    vec_t v;
    v.tag = tag; v.s = s; v.k = 4'(k); v.e = e; v.m = m; v.x = x;
    vecs.push_back(v);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.Sign        = v.s;
    bus.RegimeValue = v.k;
    bus.Exponent    = v.e;
    bus.Mantissa    = v.m;
  endtask

  task automatic xfer(input vec_t v, output logic [7:0] r, output int lat);
    @(negedge clk);
    drive(v);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    r = bus.Result;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    int lat, sent, recv, extra, seen;
    logic acc, took;
    vec_t sv[4];

    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.Sign = 1'b0; bus.RegimeValue = '0; bus.Exponent = '0; bus.Mantissa = '0;
    rst_n = 1'b0;
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.Result, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);

    add("k0_one",     0,  0, 3'd0, 8'h80, 8'h40);
    add("k0_neg",     1,  0, 3'd0, 8'h80, 8'hC0);
    add("k0_e1",      0,  0, 3'd1, 8'hC0, 8'h46);
    add("tie_even",   0,  0, 3'd0, 8'h90, 8'h40);
    add("rnd_odd",    0,  0, 3'd0, 8'hB0, RNE ? 8'h42 : 8'h41);
    add("sat_hi7",    0,  7, 3'd0, 8'h80, 8'h7F);
    add("sat_lo7",    0, -7, 3'd0, 8'h80, 8'h01);
    add("sat_hi_neg", 1,  7, 3'd0, 8'h80, 8'h81);
    add("kmax6",      0,  6, 3'd5, 8'hFF, 8'h7F);
    add("kmin8",      0, -8, 3'd7, 8'hFF, 8'h01);
    add("sat_lo_neg", 1, -7, 3'd0, 8'h80, 8'hFF);
    add("km6_rnd",    0, -6, 3'd4, 8'h80, RNE ? 8'h02 : 8'h01);
    add("k5_carry",   0,  5, 3'd7, 8'hFF, RNE ? 8'h7F : 8'h7E);
    add("km1_neg",    1, -1, 3'd2, 8'hA0, 8'hD7);
    add("km1_pos",    0, -1, 3'd2, 8'hA0, 8'h29);

    foreach (vecs[i]) begin
      xfer(vecs[i], r, lat);
      check(vecs[i].tag, r, vecs[i].x);
      check({vecs[i].tag, "_lat"}, lat, 2);
    end

    for (int i = 0; i < 100; i++) begin
      vec_t v;
      v.tag = "rand";
      v.s = 1'($urandom_range(0, 1));
      v.k = 4'($urandom_range(0, 15));
      v.e = 3'($urandom_range(0, 7));
      v.m = {1'b1, 7'($urandom_range(0, 127))};
      v.x = 8'h00;
      xfer(v, r, lat);
      check("never_zero_nar", (r == 8'h00) || (r == 8'h80), 0);
    end

    // four-word stream with the sink stalled for the first three cycles
    sv[0] = vecs[0]; sv[1] = vecs[2]; sv[2] = vecs[4]; sv[3] = vecs[13];
    sent = 0; recv = 0; extra = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      bus.out_ready = (cyc >= 3);
      bus.in_valid  = (sent < 4);
      if (sent < 4) drive(sv[sent]);
      #1;
      if (cyc == 2) begin
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_accepted", sent, 2);
      end
      if (bus.out_valid) begin
        if (recv < 4) check($sformatf("stream_%0d", recv), bus.Result, sv[recv].x);
        else extra++;
      end
      acc  = bus.in_valid && bus.in_ready;
      took = bus.out_valid && bus.out_ready;
      @(posedge clk);
      if (acc)  sent++;
      if (took) recv++;
    end
    check("stream_count", recv, 4);
    check("stream_extra", extra, 0);

    // fill both stages, then reset away from any clock edge
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(vecs[0]);
    @(posedge clk);
    @(negedge clk);
    drive(vecs[1]);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("full_before_rst", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus.out_valid, 0);
    check("async_rst_result", bus.Result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("no_stale_after_rst", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/posit_construction.md
Name: posit_construction

Overview:
- Posit encoder: packs sign, regime value, exponent and hidden-bit mantissa fields into an N-bit posit word.
- Rounds round-to-nearest-even (RNE) and saturates.
- Inverse of the posit field-extraction stage; sits at the output of posit arithmetic units (adder/multiplier), after normalisation.
- Two-stage elastic pipeline with valid/ready handshake on both sides.

Parameters:
- N, 8, posit word width.
- ES, 3, exponent field width.
- RS, log2(N), regime value width minus 1 (RegimeValue is RS+1 bits signed).

Ports:
- clk  in  1  clock, all state rises on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input fields valid.
- in_ready  out  1  block accepts input this cycle.
- Sign  in  1  result sign.
- RegimeValue  in  RS+1 signed  regime k.
- Exponent  in  ES  exponent field.
- Mantissa  in  N-ES+3  MSB is hidden 1, rest fraction, MSB-first.
- out_valid  out  1  Result valid.
- out_ready  in  1  downstream accepts.
- Result  out  N  encoded posit.

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, Result='0, all pipeline data regs '0. in_ready=1 one cycle after release.
- Transfer occurs when valid&&ready on a side. Latency: input transfer at edge t → out_valid=1 after edge t+1 (2 register stages). Throughput 1 per cycle while out_ready=1.
- Stall: stage2 holds when out_valid && !out_ready. Stage1 advances when stage2 empty or advancing. in_ready = !s1_valid || s1_advance (combinational from out_ready, no skid buffer).
- Result, out_valid stable while out_valid && !out_ready.
- Stage1 (magnitude build):
  - k>=0: regime = (k+1) ones then one 0.
  - k<0: regime = -k zeros then one 1.
  - Concatenate {regime, Exponent, Mantissa[N-ES+1:0]} into an extended vector of 2N+ES bits, left-aligned.
  - Register the top N-1 bits (magnitude), guard bit (next bit) and sticky (OR of all remaining bits), plus Sign and a saturation flag.
- Saturation flags (set in stage1):
  - k >= N-2: magnitude forced to maxpos (all N-1 bits 1).
  - k <= -(N-1): magnitude forced to minpos (0...01).
  - Rounding is not applied on saturated words.
- Stage2 (round and sign):
  - Round up when guard && (sticky || lsb).
  - Rounding carry past maxpos clamps to maxpos.
  - Magnitude never rounds to 0: zero result is forced to minpos.
  - Result = Sign ? {1'b1, ~mag+1} (two's complement of {0,mag}) : {0,mag}.
  - Result is never 0x00 or NaR (1 followed by zeros).
- Reset mid-operation: in-flight words are discarded and no out_valid is produced for them.
- Back-to-back inputs with out_ready toggling: no loss, no duplication, order preserved.

Optional Feature:
- POSIT_RNE_EN defined: RNE rounding as above.
- POSIT_RNE_EN undefined: truncation. Guard and sticky are neither computed nor registered; magnitude is the top N-1 bits. Saturation and the never-zero rule to minpos still apply.
- Latency and handshake are identical in both builds.

Decomposition:
- Package posit_pkg holds:
  - log2 function.
  - Default N, ES and derived RS.
  - Regime clamp constants K_MAX=N-2, K_MIN=-(N-1).
  - Typedef of the stage1 payload struct {sign, sat, mag, guard, sticky}.
- One combinational sub-module, posit_regime_encoder: takes k, outputs the left-aligned regime bit pattern and its length. Instantiated in stage1.

Test Plan (N=8, ES=3):
- Sign=0, k=0, E=0, M=8'b1000_0000, out_ready=1 → Result=0x40 two cycles later. Same with Sign=1 → 0xC0.
- k=0, E=1, M=8'b1100_0000 → 0x46. Tie case M=8'b1001_0000 → 0x40 (tie to even). M=8'b1011_0000 → 0x42.
- k=7 → 0x7F. k=-7 → 0x01. Sign=1, k=7 → 0x81. Never 0x00 or 0x80 across a full random sweep.
- Stream 4 words with out_ready held 0 for 3 cycles: in_ready drops after 2 accepted, outputs emerge in order, Result stable while stalled.
- Assert rst_n low with both stages full: out_valid=0 and Result=0 immediately (async); no stale output after release.
- Build without POSIT_RNE_EN: M=8'b1011_0000, k=0, E=0 → 0x41 (truncated).
